key_click_decoder: RTL and testbench



---
 rtl/key_click_decoder.sv | 132 +++++++++++++
 tb/tb_key_click_decoder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_click_decoder.sv
// Gesture classifier for a debounced key: short press, double click,
// long press and auto-repeat, all as registered one-cycle pulses.
module key_click_decoder #(
    parameter int CNT_W      = 26,
    parameter int LONG_CNT   = 50_000_000,
    parameter int DOUBLE_GAP = 15_000_000,
    parameter int REPEAT_CNT = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_value,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } state_t;

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(DOUBLE_GAP - 1);
    localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CNT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             short_press_q, short_press_d;
    logic             double_click_q, double_click_d;
    logic             long_press_q, long_press_d;
    logic             repeat_pulse_q, repeat_pulse_d;
    logic             busy_q, busy_d;
    logic             press_ev;
    logic             rel_ev;
    logic             rep_clr;
    logic             timed;

    assign press_ev = key_flag & ~key_value;
    assign rel_ev   = key_flag & key_value;

    always_comb begin
        state_d        = state_q;
        short_press_d  = 1'b0;
        double_click_d = 1'b0;
        long_press_d   = 1'b0;
        repeat_pulse_d = 1'b0;
        rep_clr        = 1'b0;
        timed          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press_ev) state_d = PRESS1;
            end
            PRESS1: begin
                timed = 1'b1;
                if (rel_ev) begin
                    state_d = WAIT2;
                end else if (timer_q == LONG_TC) begin
                    state_d      = LONG;
                    long_press_d = 1'b1;
                end
            end
            WAIT2: begin
                timed = 1'b1;
                if (press_ev) begin
                    state_d = PRESS2;
                end else if (timer_q == GAP_TC) begin
                    state_d       = IDLE;
                    short_press_d = 1'b1;
                end
            end
            PRESS2: begin
                if (rel_ev) begin
                    state_d        = IDLE;
                    double_click_d = 1'b1;
                end
            end
            LONG: begin
                timed = 1'b1;
                if (rel_ev) begin
                    state_d = IDLE;
                end else if (timer_q == REP_TC) begin
                    repeat_pulse_d = 1'b1;
                    rep_clr        = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Any state change or repeat tick restarts the gesture timer
        timer_d = timer_q;
        if ((state_d != state_q) || rep_clr) begin
            timer_d = '0;
        end else if (timed) begin
            timer_d = timer_q + CNT_W'(1);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            short_press_q  <= 1'b0;
            double_click_q <= 1'b0;
            long_press_q   <= 1'b0;
            repeat_pulse_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            short_press_q  <= short_press_d;
            double_click_q <= double_click_d;
            long_press_q   <= long_press_d;
            repeat_pulse_q <= repeat_pulse_d;
            busy_q         <= busy_d;
        end
    end

    assign short_press  = short_press_q;
    assign double_click = double_click_q;
    assign long_press   = long_press_q;
    assign repeat_pulse = repeat_pulse_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_key_click_decoder.sv
// Scoreboard bench for key_click_decoder: an event-driven gesture model
// predicts pulse times and busy windows; a monitor checks every cycle.
module tb_key_click_decoder;

    localparam int LC   = 20;
    localparam int DG   = 10;
    localparam int RC   = 5;
    localparam int MAXH = 1000;

    localparam int S_NONE  = 0;
    localparam int S_PRESS = 1;
    localparam int S_REL   = 2;
    localparam int S_RST   = 3;

    localparam int K_SHORT = 1;
    localparam int K_DBL   = 2;
    localparam int K_LONG  = 3;
    localparam int K_REP   = 4;

    logic clk = 1'b0;
    logic rst;
    logic key_flag;
    logic key_value;
    logic short_press;
    logic double_click;
    logic long_press;
    logic repeat_pulse;
    logic busy;

    always #5 clk = ~clk;

    key_click_decoder #(
        .CNT_W     (8),
        .LONG_CNT  (LC),
        .DOUBLE_GAP(DG),
        .REPEAT_CNT(RC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_flag    (key_flag),
        .key_value   (key_value),
        .short_press (short_press),
        .double_click(double_click),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .busy        (busy)
    );

    typedef struct {
        int cyc;
        int kind;
    } pulse_t;

    typedef enum {
        G_IDLE,
        G_HELD1,
        G_GAP,
        G_HELD2,
        G_LONG
    } gest_t;

    pulse_t exp_q[$];
    int     stim[MAXH];
    bit     exp_busy[MAXH];
    int     horizon;
    int     total = 0;
    int     bad   = 0;

    gest_t  gp;
    int     ent;
    int     bstart;

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic emit(int c, int k);
        pulse_t p;
        if (c < horizon) begin
            p.cyc  = c;
            p.kind = k;
            exp_q.push_back(p);
        end
    endtask

    task automatic go_idle(int c);
        for (int i = bstart; i < c && i < horizon; i++) exp_busy[i] = 1'b1;
        gp = G_IDLE;
    endtask

    // Apply every timeout whose deadline falls strictly before cycle t
    task automatic resolve(int t);
        bit done;
        done = 1'b0;
        while (!done) begin
            case (gp)
                G_HELD1: begin
                    if (ent + LC - 1 < t) begin
                        emit(ent + LC, K_LONG);
                        gp  = G_LONG;
                        ent = ent + LC;
                    end else done = 1'b1;
                end
                G_GAP: begin
                    if (ent + DG - 1 < t) begin
                        emit(ent + DG, K_SHORT);
                        go_idle(ent + DG);
                    end else done = 1'b1;
                end
                G_LONG: begin
                    if (ent + RC - 1 < t) begin
                        emit(ent + RC, K_REP);
                        ent = ent + RC;
                    end else done = 1'b1;
                end
                default: done = 1'b1;
            endcase
        end
    endtask

    task automatic model();
        exp_q.delete();
        for (int i = 0; i < MAXH; i++) exp_busy[i] = 1'b0;
        gp     = G_IDLE;
        ent    = 0;
        bstart = 0;
        for (int t = 0; t < horizon; t++) begin
            if (stim[t] != S_NONE) begin
                resolve(t);
                if (stim[t] == S_RST) begin
                    if (gp != G_IDLE) go_idle(t + 1);
                end else if (stim[t] == S_PRESS) begin
                    if (gp == G_IDLE) begin
                        gp     = G_HELD1;
                        ent    = t + 1;
                        bstart = t + 1;
                    end else if (gp == G_GAP) begin
                        gp = G_HELD2;
                    end
                end else begin
                    if (gp == G_HELD1) begin
                        gp  = G_GAP;
                        ent = t + 1;
                    end else if (gp == G_HELD2) begin
                        emit(t + 1, K_DBL);
                        go_idle(t + 1);
                    end else if (gp == G_LONG) begin
                        go_idle(t + 1);
                    end
                end
            end
        end
        resolve(horizon);
        if (gp != G_IDLE) go_idle(horizon);
    endtask

    task automatic apply(int s);
        rst       = (s == S_RST);
        key_flag  = (s == S_PRESS) || (s == S_REL);
        if (s == S_PRESS) key_value = 1'b0;
        else if (s == S_REL) key_value = 1'b1;
        else key_value = 1'($urandom_range(0, 1));
    endtask

    task automatic monitor(string nm, int c);
        int     n;
        int     k;
        pulse_t p;
        n = int'(short_press) + int'(double_click)
          + int'(long_press) + int'(repeat_pulse);
        if (n > 0) begin
            k = short_press ? K_SHORT : double_click ? K_DBL :
                long_press ? K_LONG : K_REP;
            check($sformatf("%s one-hot c=%0d", nm, c), n, 1);
            if (exp_q.size() == 0) begin
                check($sformatf("%s unexpected pulse c=%0d", nm, c), k, 0);
            end else begin
                p = exp_q.pop_front();
                check($sformatf("%s pulse cycle", nm), c, p.cyc);
                check($sformatf("%s pulse kind c=%0d", nm, c), k, p.kind);
            end
        end
        check($sformatf("%s busy c=%0d", nm, c), int'(busy), int'(exp_busy[c]));
    endtask

    task automatic clear_stim(int h);
        horizon = h;
        for (int i = 0; i < MAXH; i++) stim[i] = S_NONE;
    endtask

    task automatic run_scn(string nm);
        model();
        apply(S_RST);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check($sformatf("%s reset outputs", nm),
              int'({short_press, double_click, long_press, repeat_pulse, busy}), 0);
        @(posedge clk);
        #1;
        fork
            begin
                for (int c = 0; c < horizon; c++) begin
                    apply(stim[c]);
                    @(posedge clk);
                    #1;
                end
                apply(S_NONE);
            end
            begin
                for (int c = 0; c < horizon; c++) begin
                    @(negedge clk);
                    monitor(nm, c);
                end
            end
        join
        check($sformatf("%s missing pulses", nm), exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic gen_random(int h);
        int  t;
        int  r;
        bit  held;
        clear_stim(h);
        held = 1'b0;
        t = int'($urandom_range(0, 5));
        while (t < h - 60) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                stim[t] = S_RST;
            end else if (r < 18) begin
                stim[t] = held ? S_PRESS : S_REL;
            end else begin
                stim[t] = held ? S_REL : S_PRESS;
                held    = ~held;
            end
            t += int'($urandom_range(1, 30));
        end
    endtask

    initial begin
        rst       = 1'b1;
        key_flag  = 1'b0;
        key_value = 1'b1;

        clear_stim(40);
        stim[0] = S_PRESS; stim[5] = S_REL;
        run_scn("short");

        clear_stim(40);
        stim[0] = S_PRESS; stim[5] = S_REL;
        stim[9] = S_PRESS; stim[12] = S_REL;
        run_scn("double");

        clear_stim(60);
        stim[0] = S_PRESS; stim[40] = S_REL;
        run_scn("long");

        clear_stim(50);
        stim[0] = S_PRESS; stim[19] = S_REL;
        run_scn("rel_19");

        clear_stim(50);
        stim[0] = S_PRESS; stim[20] = S_REL;
        run_scn("rel_at_long_tc");

        clear_stim(40);
        stim[0] = S_PRESS; stim[5] = S_REL;
        stim[15] = S_PRESS; stim[18] = S_REL;
        run_scn("press_at_gap_tc");

        clear_stim(40);
        stim[2] = S_REL; stim[4] = S_PRESS;
        stim[7] = S_PRESS; stim[9] = S_REL;
        run_scn("spurious");

        clear_stim(60);
        stim[0] = S_PRESS; stim[30] = S_RST; stim[40] = S_REL;
        run_scn("rst_mid_long");

        clear_stim(50);
        stim[0] = S_PRESS; stim[5] = S_REL;
        stim[9] = S_PRESS; stim[12] = S_REL;
        stim[14] = S_PRESS; stim[16] = S_REL;
        run_scn("third_click");

        for (int i = 0; i < 8; i++) begin
            gen_random(400);
            run_scn($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
